df_sig_gen: RTL and testbench



---
 rtl/df_sig_gen.sv | 269 ++++++++++++++++++++++++++
 tb/tb_df_sig_gen.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/df_sig_gen.sv
// df_sig_gen: burst stimulus generator for the digital filter input path.
// It emits one 8-bit sample per clock: rectangle, triangle, sine or a
// Dirac impulse, with a programmable half-period H.
// Optional feature macro: DF_SIG_GEN_SINE_EN. When it is defined, the sine
// quarter table and the phase path are compiled in. When it is undefined,
// shape 2'b10 behaves exactly like rect.
module df_sig_gen #(
  parameter int unsigned BURST_LEN = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] shape,
  input  logic [4:0] half_presc,
  output logic [7:0] sample,
  output logic       valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SH_RECT  = 2'b00;
  localparam logic [1:0] SH_TRI   = 2'b01;
  localparam logic [1:0] SH_SINE  = 2'b10;
  localparam logic [1:0] SH_DIRAC = 2'b11;

  localparam logic [10:0] BURST_LEN_W = 11'(BURST_LEN);
  localparam logic [9:0]  BURST_LEN_N = 10'(BURST_LEN);

  state_t      state_q;
  logic [1:0]  shape_q;
  logic [4:0]  h_q;        // effective half-period, never zero
  logic [2:0]  step_q;     // divider step counter
  logic [7:0]  dq_q;       // dividend shifting out, quotient shifting in
  logic [4:0]  rem_q;      // divider remainder, then r = D mod H
  logic [7:0]  acc_q;      // triangle value or sine phase
  logic [4:0]  rr_q;       // running remainder of the incremental ramp
  logic [5:0]  k_q;        // position inside the period, 0..2H-1
  logic [9:0]  n_q;        // samples emitted so far
  logic [7:0]  sample_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  assign sample = sample_q;
  assign valid  = valid_q;
  assign busy   = busy_q;
  assign done   = done_q;

  // Values latched on an accepted start
  logic [1:0] shape_d;
  logic [4:0] h_d;
  logic [7:0] dividend_d;

  // Select the shape, half-period and dividend captured on start
  always_comb begin
    h_d = (half_presc == 5'd0) ? 5'd1 : half_presc;
`ifdef DF_SIG_GEN_SINE_EN
    shape_d    = shape;
    dividend_d = (shape == SH_SINE) ? 8'd128 : 8'd255;
`else
    shape_d    = (shape == SH_SINE) ? SH_RECT : shape;
    dividend_d = 8'd255;
`endif
  end

  // One restoring-divider step: shift in the next dividend bit, try subtracting H
  logic [5:0] div_shift;
  logic       div_ge;
  logic [4:0] rem_next;
  logic [7:0] dq_next;

  always_comb begin
    div_shift = {rem_q, dq_q[7]};
    div_ge    = (div_shift >= {1'b0, h_q});
    // The true result is below H, so 5-bit modular arithmetic is exact
    rem_next  = div_ge ? (div_shift[4:0] - h_q) : div_shift[4:0];
    dq_next   = {dq_q[6:0], div_ge};
  end

  // Incremental ramp: advance or retreat floor(D*j/H) by q/r with a remainder carry
  logic [5:0] two_h;
  logic [5:0] sum_r;
  logic       up_carry;
  logic [4:0] rr_up;
  logic [7:0] acc_up;
  logic       dn_borrow;
  logic [4:0] rr_dn;
  logic [7:0] acc_dn;
  logic       tri_rising;
  logic       k_last;
  logic       period_over;

  always_comb begin
    two_h      = {h_q, 1'b0};
    sum_r      = {1'b0, rr_q} + {1'b0, rem_q};
    up_carry   = (sum_r >= {1'b0, h_q});
    rr_up      = up_carry ? (sum_r[4:0] - h_q) : sum_r[4:0];
    acc_up     = acc_q + dq_q + {7'd0, up_carry};
    dn_borrow  = (rr_q < rem_q);
    rr_dn      = dn_borrow ? (rr_q + h_q - rem_q) : (rr_q - rem_q);
    acc_dn     = acc_q - dq_q - {7'd0, dn_borrow};
    tri_rising = (k_q < {1'b0, h_q});
    k_last     = (k_q == (two_h - 6'd1));
    period_over = (({1'b0, n_q} + {5'd0, two_h}) > BURST_LEN_W);
  end

`ifdef DF_SIG_GEN_SINE_EN
  // Quarter-wave table: round(127*sin(2*pi*k/256)) for k = 0..64
  function automatic logic [6:0] sine_quarter(input logic [6:0] k);
    logic [6:0] v;
    case (k)
      7'd0:  v = 7'd0;   7'd1:  v = 7'd3;   7'd2:  v = 7'd6;   7'd3:  v = 7'd9;
      7'd4:  v = 7'd12;  7'd5:  v = 7'd16;  7'd6:  v = 7'd19;  7'd7:  v = 7'd22;
      7'd8:  v = 7'd25;  7'd9:  v = 7'd28;  7'd10: v = 7'd31;  7'd11: v = 7'd34;
      7'd12: v = 7'd37;  7'd13: v = 7'd40;  7'd14: v = 7'd43;  7'd15: v = 7'd46;
      7'd16: v = 7'd49;  7'd17: v = 7'd51;  7'd18: v = 7'd54;  7'd19: v = 7'd57;
      7'd20: v = 7'd60;  7'd21: v = 7'd63;  7'd22: v = 7'd65;  7'd23: v = 7'd68;
      7'd24: v = 7'd71;  7'd25: v = 7'd73;  7'd26: v = 7'd76;  7'd27: v = 7'd78;
      7'd28: v = 7'd81;  7'd29: v = 7'd83;  7'd30: v = 7'd85;  7'd31: v = 7'd88;
      7'd32: v = 7'd90;  7'd33: v = 7'd92;  7'd34: v = 7'd94;  7'd35: v = 7'd96;
      7'd36: v = 7'd98;  7'd37: v = 7'd100; 7'd38: v = 7'd102; 7'd39: v = 7'd104;
      7'd40: v = 7'd106; 7'd41: v = 7'd107; 7'd42: v = 7'd109; 7'd43: v = 7'd111;
      7'd44: v = 7'd112; 7'd45: v = 7'd113; 7'd46: v = 7'd115; 7'd47: v = 7'd116;
      7'd48: v = 7'd117; 7'd49: v = 7'd118; 7'd50: v = 7'd120; 7'd51: v = 7'd121;
      7'd52: v = 7'd122; 7'd53: v = 7'd122; 7'd54: v = 7'd123; 7'd55: v = 7'd124;
      7'd56: v = 7'd125; 7'd57: v = 7'd125; 7'd58: v = 7'd126; 7'd59: v = 7'd126;
      7'd60: v = 7'd126; 7'd61: v = 7'd127; 7'd62: v = 7'd127; 7'd63: v = 7'd127;
      default: v = 7'd127;
    endcase
    return v;
  endfunction

  logic [6:0] sine_idx;
  logic [6:0] sine_mag;
  logic [7:0] sine_val;

  // Fold the 8-bit phase onto the quarter table and apply the half-wave sign
  always_comb begin
    // Second quarter mirrors the first: index 128-p, i.e. -p mod 128
    sine_idx = (acc_q[6:0] > 7'd64) ? (7'd0 - acc_q[6:0]) : acc_q[6:0];
    sine_mag = sine_quarter(sine_idx);
    sine_val = acc_q[7] ? (8'd128 - {1'b0, sine_mag}) : (8'd128 + {1'b0, sine_mag});
  end
`endif

  // Sample for the current position and the ramp state for the next one
  logic [7:0] run_sample;
  logic [7:0] acc_step;
  logic [4:0] rr_step;
  logic       run_end;

  always_comb begin
    run_sample = 8'h00;
    acc_step   = acc_q;
    rr_step    = rr_q;
    run_end    = (k_q == 6'd0) && period_over;
    case (shape_q)
      SH_TRI: begin
        run_sample = acc_q;
        if (tri_rising) begin
          acc_step = acc_up;
          rr_step  = rr_up;
        end else begin
          acc_step = acc_dn;
          rr_step  = rr_dn;
        end
      end
`ifdef DF_SIG_GEN_SINE_EN
      SH_SINE: begin
        // Phase wraps through 256 exactly at the period end, so it never resets
        run_sample = sine_val;
        acc_step   = acc_up;
        rr_step    = rr_up;
      end
`endif
      SH_DIRAC: begin
        run_sample = (n_q == 10'd9) ? 8'hFF : 8'h00;
        run_end    = (n_q == BURST_LEN_N);
      end
      default: begin
        run_sample = tri_rising ? 8'h00 : 8'hFF;
      end
    endcase
  end

  // Control FSM with registered outputs: IDLE -> DIV (8 steps) -> RUN -> DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      shape_q  <= SH_RECT;
      h_q      <= 5'd1;
      step_q   <= 3'd0;
      dq_q     <= 8'd0;
      rem_q    <= 5'd0;
      acc_q    <= 8'd0;
      rr_q     <= 5'd0;
      k_q      <= 6'd0;
      n_q      <= 10'd0;
      sample_q <= 8'h00;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_DIV;
            busy_q  <= 1'b1;
            shape_q <= shape_d;
            h_q     <= h_d;
            dq_q    <= dividend_d;
            rem_q   <= 5'd0;
            step_q  <= 3'd0;
            acc_q   <= 8'd0;
            rr_q    <= 5'd0;
            k_q     <= 6'd0;
            n_q     <= 10'd0;
          end
        end
        S_DIV: begin
          dq_q   <= dq_next;
          rem_q  <= rem_next;
          step_q <= step_q + 3'd1;
          if (step_q == 3'd7) begin
            // A period longer than the whole burst yields no samples at all
            if ((shape_q != SH_DIRAC) && ({5'd0, two_h} > BURST_LEN_W)) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (run_end) begin
            state_q  <= S_DONE;
            sample_q <= 8'h00;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            sample_q <= run_sample;
            valid_q  <= 1'b1;
            n_q      <= n_q + 10'd1;
            acc_q    <= acc_step;
            rr_q     <= rr_step;
            k_q      <= k_last ? 6'd0 : (k_q + 6'd1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_df_sig_gen.sv
// Directed bench for df_sig_gen: bursts of every shape, boundary half-periods,
// start during RUN and reset during a burst.
module tb_df_sig_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] shape;
  logic [4:0] half_presc;
  logic [7:0] sample;
  logic       valid;
  logic       busy;
  logic       done;

  df_sig_gen #(.BURST_LEN(250)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .shape      (shape),
    .half_presc (half_presc),
    .sample     (sample),
    .valid      (valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // Results of the most recent burst
  logic [7:0] cap [0:1023];
  int cap_len;
  int first_edge;
  int done_edge;
  int done_cycles;
  int bad_done_out;
  int busy0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Start a burst and record every valid sample plus done timing; edges are
  // counted from the edge that accepts start (edge 0).
  task automatic run_burst(input logic [1:0] sh, input logic [4:0] h, input int restart_edge);
    int e;
    bit fin;
    @(negedge clk);
    start = 1'b1; shape = sh; half_presc = h;
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = int'(busy);
    cap_len = 0; first_edge = -1; done_edge = -1; done_cycles = 0; bad_done_out = 0;
    e = 0; fin = 0;
    while (!fin && e < 1200) begin
      if (e + 1 == restart_edge) begin
        start = 1'b1; shape = 2'b01; half_presc = 5'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      e++;
      if (valid) begin
        if (first_edge < 0) first_edge = e;
        if (cap_len < 1024) cap[cap_len] = sample;
        cap_len++;
      end
      if (done) begin
        if (done_edge < 0) done_edge = e;
        done_cycles++;
        if (sample !== 8'h00 || valid !== 1'b0 || busy !== 1'b0) bad_done_out++;
      end else if (done_edge >= 0) begin
        fin = 1;
      end
    end
  endtask

  function automatic int rect_errs(input int h, input int len);
    int errs = 0;
    for (int j = 0; j < len; j++)
      if (cap[j] !== (((j % (2 * h)) < h) ? 8'h00 : 8'hFF)) errs++;
    return errs;
  endfunction

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] tri_tab [4];
    int errs;
    int cnt;
    int e;
    tri_tab = '{8'h00, 8'h7F, 8'hFF, 8'h7F};

    rst_n = 1'b0; start = 1'b0; shape = 2'b00; half_presc = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sample", sample, 8'h00);
    chk("reset_valid", valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Rect H=25: 5 periods of 25x00 + 25xFF
    run_burst(2'b00, 5'd25, -1);
    $display("[TB] rect H=25: len=%0d first=%0d done_edge=%0d", cap_len, first_edge, done_edge);
    chk("rect25_busy_after_start", busy0, 1);
    chk("rect25_first_valid_edge", first_edge, 9);
    chk("rect25_len", cap_len, 250);
    chk("rect25_pattern_errs", rect_errs(25, 250), 0);
    chk("rect25_done_edge", done_edge, 259);
    chk("rect25_done_width", done_cycles, 1);
    chk("rect25_outputs_at_done", bad_done_out, 0);

    // Triangle H=2: 00 7F FF 7F repeated, 248 samples
    run_burst(2'b01, 5'd2, -1);
    $display("[TB] tri H=2: len=%0d done_edge=%0d", cap_len, done_edge);
    errs = 0;
    for (int j = 0; j < 248; j++) if (cap[j] !== tri_tab[j % 4]) errs++;
    chk("tri2_len", cap_len, 248);
    chk("tri2_pattern_errs", errs, 0);
    chk("tri2_done_edge", done_edge, 9 + 248);

    // Sine H=10 (rect of H=10 when the sine path is not built)
    run_burst(2'b10, 5'd10, -1);
    $display("[TB] sine H=10: len=%0d done_edge=%0d", cap_len, done_edge);
    chk("sine10_len", cap_len, 240);
`ifdef DF_SIG_GEN_SINE_EN
    chk("sine10_j0", cap[0], 8'h80);
    chk("sine10_j1", cap[1], 8'hA5);
    chk("sine10_j5", cap[5], 8'hFF);
    chk("sine10_j10", cap[10], 8'h80);
    chk("sine10_j13", cap[13], 8'h1A);
    chk("sine10_j15", cap[15], 8'h01);
    chk("sine10_j35_next_period", cap[35], 8'h01);
`else
    chk("sine10_as_rect_errs", rect_errs(10, 240), 0);
`endif

    // Dirac: 250 samples, only index 9 is FF
    run_burst(2'b11, 5'd7, -1);
    $display("[TB] dirac: len=%0d done_edge=%0d", cap_len, done_edge);
    errs = 0;
    for (int j = 0; j < 250; j++) if (j != 9 && cap[j] !== 8'h00) errs++;
    chk("dirac_len", cap_len, 250);
    chk("dirac_idx9", cap[9], 8'hFF);
    chk("dirac_other_errs", errs, 0);

    // H=0 behaves as H=1: alternating 00/FF
    run_burst(2'b00, 5'd0, -1);
    $display("[TB] rect H=0: len=%0d", cap_len);
    chk("rect0_len", cap_len, 250);
    chk("rect0_pattern_errs", rect_errs(1, 250), 0);

    // H=31 with a start pulse during RUN (edge 50) that must be ignored
    run_burst(2'b00, 5'd31, 50);
    $display("[TB] rect H=31 restart ignored: len=%0d done_edge=%0d", cap_len, done_edge);
    chk("rect31_len", cap_len, 248);
    chk("rect31_pattern_errs", rect_errs(31, 248), 0);
    chk("rect31_done_width", done_cycles, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rect31_idle_after", busy, 1'b0);

    // Reset asserted at sample 100 of a rect burst
    @(negedge clk);
    start = 1'b1; shape = 2'b00; half_presc = 5'd25;
    @(posedge clk); #1;
    start = 1'b0;
    cnt = 0; e = 0;
    while (cnt < 100 && e < 400) begin
      @(posedge clk); #1;
      e++;
      if (valid) cnt++;
    end
    chk("abort_reached_sample100", cnt, 100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("[TB] reset at sample 100: sample=%0h valid=%0b busy=%0b done=%0b", sample, valid, busy, done);
    chk("abort_sample", sample, 8'h00);
    chk("abort_valid", valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    errs = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) errs++;
    end
    chk("abort_no_activity_after", errs, 0);

    run_burst(2'b00, 5'd25, -1);
    $display("[TB] rect H=25 after reset: len=%0d done_edge=%0d", cap_len, done_edge);
    chk("post_reset_len", cap_len, 250);
    chk("post_reset_pattern_errs", rect_errs(25, 250), 0);
    chk("post_reset_done_edge", done_edge, 259);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
